// File: rtl/seg7_scan_driver.sv
// Common-anode 7-segment scan driver: advances one digit per rising edge of the slow_clk strobe,
// with frame-wrap shadow capture for tear-free display. Optional build macro: SEG7_LEADING_ZERO_BLANK_EN.
module seg7_scan_driver #(
    parameter int NUM_DIGITS = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      slow_clk,
    input  logic                      enable,
    input  logic [4*NUM_DIGITS-1:0]   value,
    output logic [NUM_DIGITS-1:0]     anode,
    output logic [6:0]                seg
);

    localparam int                IDX_W    = $clog2(NUM_DIGITS);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_DIGITS - 1);
    localparam logic [6:0]        SEG_OFF  = 7'h7F;

    logic                     slow_d;
    logic                     tick;
    logic [IDX_W-1:0]         idx;
    logic [4*NUM_DIGITS-1:0]  shadow;
    logic [3:0]               cur_digit;
    logic                     cur_blank;
    logic [NUM_DIGITS-1:0]    anode_next;
    logic [6:0]               seg_next;

    // Active-low {g,f,e,d,c,b,a} patterns.
    function automatic logic [6:0] hex7(input logic [3:0] d);
        case (d)
            4'h0: hex7 = 7'b1000000;
            4'h1: hex7 = 7'b1111001;
            4'h2: hex7 = 7'b0100100;
            4'h3: hex7 = 7'b0110000;
            4'h4: hex7 = 7'b0011001;
            4'h5: hex7 = 7'b0010010;
            4'h6: hex7 = 7'b0000010;
            4'h7: hex7 = 7'b1111000;
            4'h8: hex7 = 7'b0000000;
            4'h9: hex7 = 7'b0010000;
            4'hA: hex7 = 7'b0001000;
            4'hB: hex7 = 7'b0000011;
            4'hC: hex7 = 7'b1000110;
            4'hD: hex7 = 7'b0100001;
            4'hE: hex7 = 7'b0000110;
            default: hex7 = 7'b0001110;
        endcase
    endfunction

    // slow_d resets high so a strobe already high at reset release is not a new edge.
    assign tick = slow_clk & ~slow_d;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            slow_d <= 1'b1;
            idx    <= '0;
            shadow <= '0;
        end else begin
            slow_d <= slow_clk;
            if (tick) begin
                if (idx == LAST_IDX) begin
                    idx    <= '0;
                    shadow <= value;
                end else begin
                    idx <= idx + IDX_W'(1);
                end
            end
        end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        cur_digit  = 4'h0;
        anode_next = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                cur_digit     = shadow[4*i +: 4];
                anode_next[i] = 1'b0;
            end
        end
    end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    logic [NUM_DIGITS-1:0] blank_mask;

    // A digit is a leading zero when it and every more significant digit are zero; digit 0 always shows.
    always_comb begin
        logic zero_run;
        zero_run   = 1'b1;
        blank_mask = '0;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            zero_run      = zero_run & (shadow[4*i +: 4] == 4'h0);
            blank_mask[i] = zero_run;
        end
    end

    always_comb begin
        cur_blank = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                cur_blank = blank_mask[i];
            end
        end
    end
`else
    assign cur_blank = 1'b0;
`endif

    assign seg_next = cur_blank ? SEG_OFF : hex7(cur_digit);

    // Output stage lags idx by one clk; enable gates the pins only, never the scan.
    always_ff @(posedge clk) begin
        if (reset) begin
            anode <= '1;
            seg   <= SEG_OFF;
        end else if (enable) begin
            anode <= anode_next;
            seg   <= seg_next;
        end else begin
            anode <= '1;
            seg   <= SEG_OFF;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver (NUM_DIGITS=4): reset, scan order, tearing, enable gating,
// static strobe, fast strobe, reset mid-frame and leading-zero display.
module tb_seg7_scan_driver;

    logic        clk = 1'b0;
    logic        reset;
    logic        slow_clk;
    logic        enable;
    logic [15:0] value;
    logic [3:0]  anode;
    logic [6:0]  seg;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] SA = 7'b0001000;
    localparam logic [6:0] SC = 7'b1000110;
    localparam logic [6:0] SD = 7'b0100001;
    localparam logic [6:0] BL = 7'h7F;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    localparam logic [6:0] ZHI = BL;
`else
    localparam logic [6:0] ZHI = S0;
`endif

    seg7_scan_driver #(.NUM_DIGITS(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .slow_clk (slow_clk),
        .enable   (enable),
        .value    (value),
        .anode    (anode),
        .seg      (seg)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [3:0] exp_an, input logic [6:0] exp_seg);
        n_checks++;
        assert (anode === exp_an)
        else begin
            n_errors++;
            $error("FAIL %s anode: observed %b expected %b", tag, anode, exp_an);
        end
        n_checks++;
        assert (seg === exp_seg)
        else begin
            n_errors++;
            $error("FAIL %s seg: observed %b expected %b", tag, seg, exp_seg);
        end
    endtask

    // One divide-by-4 strobe period: 4 clk low, 4 clk high.
    task automatic strobe();
        slow_clk = 1'b0;
        repeat (4) step();
        slow_clk = 1'b1;
        repeat (4) step();
    endtask

    initial begin
        reset    = 1'b1;
        slow_clk = 1'b1;
        enable   = 1'b1;
        value    = 16'h1234;

        repeat (10) step();
        check("reset_hold", 4'hF, BL);

        reset = 1'b0;
        repeat (5) step();
        check("release_no_tick", 4'b1110, S0);

        // First tick: anode moves exactly 2 edges after slow_clk is sampled high.
        slow_clk = 1'b0;
        repeat (4) step();
        slow_clk = 1'b1;
        step();
        check("latency_1edge", 4'b1110, S0);
        step();
        check("latency_2edge", 4'b1101, ZHI);
        repeat (2) step();

        strobe(); check("preframe_idx2", 4'b1011, ZHI);
        strobe(); check("preframe_idx3", 4'b0111, ZHI);

        strobe(); check("scan_d0", 4'b1110, S4);
        strobe(); check("scan_d1", 4'b1101, S3);
        strobe(); check("scan_d2", 4'b1011, S2);
        strobe(); check("scan_d3", 4'b0111, S1);
        strobe(); check("scan_wrap", 4'b1110, S4);

        strobe(); check("tear_d1", 4'b1101, S3);
        value = 16'hABCD;
        strobe(); check("tear_d2", 4'b1011, S2);
        strobe(); check("tear_d3", 4'b0111, S1);
        strobe(); check("tear_new_d0", 4'b1110, SD);
        strobe(); check("tear_new_d1", 4'b1101, SC);

        // Disabled for three ticks: idx 1 -> 0 while pins stay dark.
        enable = 1'b0;
        step();
        check("dis_now", 4'hF, BL);
        strobe(); check("dis_t1", 4'hF, BL);
        strobe(); check("dis_t2", 4'hF, BL);
        strobe(); check("dis_t3", 4'hF, BL);
        enable = 1'b1;
        step();
        check("reenable", 4'b1110, SD);

        repeat (20) step();
        check("static_high", 4'b1110, SD);
        slow_clk = 1'b0;
        repeat (20) step();
        check("static_low", 4'b1110, SD);

        // Divide-by-1 strobe: three rises, none missed.
        repeat (3) begin
            slow_clk = 1'b1;
            step();
            slow_clk = 1'b0;
            step();
        end
        check("fast_strobe", 4'b0111, SA);

        // Reset coincides with a rising strobe: reset wins and outputs blank.
        reset    = 1'b1;
        slow_clk = 1'b1;
        step();
        check("reset_mid", 4'hF, BL);
        reset = 1'b0;
        repeat (3) step();
        check("after_reset", 4'b1110, S0);

        value = 16'h0050;
        repeat (4) strobe();
        check("lz_d0", 4'b1110, S0);
        strobe(); check("lz_d1", 4'b1101, S5);
        strobe(); check("lz_d2", 4'b1011, ZHI);
        strobe(); check("lz_d3", 4'b0111, ZHI);
        value = 16'h0000;
        strobe(); check("zero_d0", 4'b1110, S0);
        strobe(); check("zero_d1", 4'b1101, ZHI);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
